// File: rtl/keypad_if.sv
// Key handshake bundle between keypad_scan and its consumer.
//   key_code  : accepted key, row_index*4 + col_index
//   key_valid : key_code holds an unconsumed key
//   key_ack   : consumer takes key_code (only meaningful while key_valid=1)
//   key_held  : an accepted key is still physically pressed
//   overrun   : one-cycle pulse when an unacknowledged key is overwritten
// master = scanner side, slave = consumer side.
interface keypad_if;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ack;
   logic       key_held;
   logic       overrun;

   modport master (output key_code, key_valid, key_held, overrun, input key_ack);
   modport slave  (input key_code, key_valid, key_held, overrun, output key_ack);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounce and a one-deep key holding register.
// Columns are driven one-hot active-low; each column dwells SCAN_DIV clocks and
// the rows are sampled on the last clock of the dwell.
//
// Ports:
//   clk_i    system clock
//   rst_n_i  asynchronous active-low reset
//   row_i    row sense lines, active-low (pulled up externally)
//   col_o    column drive, one-hot active-low
//   kp       keypad_if.master: key_code/key_valid/key_ack/key_held/overrun
//
// Optional build macro: KEYPAD_REPEAT_EN adds auto-repeat of a held key every
// REPEAT_CNT samples. Without it each press produces exactly one key.
//
// state    | meaning
// SCAN     | walking columns, no key candidate
// DEBOUNCE | candidate seen, column frozen, counting matching samples
// HELD     | key accepted and still pressed
// RELEASE  | key accepted, counting no-press samples before resuming the scan
module keypad_scan #(
   parameter int SCAN_DIV     = 100000,
   parameter int DEBOUNCE_CNT = 10,
   parameter int REPEAT_CNT   = 250
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [3:0] row_i,
   output logic [3:0] col_o,
   keypad_if.master   kp
);
   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);

   if (SCAN_DIV < 1 || DEBOUNCE_CNT < 1 || REPEAT_CNT < 1) begin : g_param_err
      $error("keypad_scan: SCAN_DIV, DEBOUNCE_CNT and REPEAT_CNT must be >= 1");
   end

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [1:0]    col_idx_q, col_idx_d;
   logic [3:0]    cand_q, cand_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    key_code_q;
   logic          key_valid_q;
   logic          overrun_q;
   logic          strobe;
   logic          press;
   logic [1:0]    hit_row;
   logic          emit;
   logic          rep_hit;

   assign strobe = (dwell_q == DW'(SCAN_DIV - 1));
   assign dwell_d = strobe ? '0 : dwell_q + 1'b1;
   assign press  = ~&row_i;

   // Lowest row index wins when several rows are pulled low.
   always_comb begin
      hit_row = 2'd3;
      if (!row_i[0])      hit_row = 2'd0;
      else if (!row_i[1]) hit_row = 2'd1;
      else if (!row_i[2]) hit_row = 2'd2;
   end

`ifdef KEYPAD_REPEAT_EN
   localparam int RW = $clog2(REPEAT_CNT + 1);
   logic [RW-1:0] rep_q, rep_d;

   assign rep_hit = strobe && (state_q == HELD) && press && (rep_q == RW'(REPEAT_CNT - 1));

   // Counts pressed samples in HELD only; frozen in RELEASE, restarted on acceptance.
   always_comb begin
      rep_d = rep_q;
      if (strobe && (state_q == HELD) && press)
         rep_d = rep_hit ? '0 : rep_q + 1'b1;
      if ((state_d == HELD) && ((state_q == SCAN) || (state_q == DEBOUNCE)))
         rep_d = '0;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) rep_q <= '0;
      else          rep_q <= rep_d;
   end
`else
   assign rep_hit = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      col_idx_d = col_idx_q;
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      emit      = 1'b0;
      if (strobe) begin
         case (state_q)
            SCAN: begin
               if (press) begin
                  cand_d = {hit_row, col_idx_q};
                  if (DEBOUNCE_CNT <= 1) begin
                     emit    = 1'b1;
                     state_d = HELD;
                     cnt_d   = '0;
                  end else begin
                     cnt_d   = CW'(1);
                     state_d = DEBOUNCE;
                  end
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (press && (hit_row == cand_q[3:2])) begin
                  if (cnt_q == CW'(DEBOUNCE_CNT - 1)) begin
                     emit    = 1'b1;
                     state_d = HELD;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else begin
                  state_d   = SCAN;
                  col_idx_d = col_idx_q + 2'd1;
                  cnt_d     = '0;
               end
            end
            HELD: begin
               if (!press) begin
                  if (DEBOUNCE_CNT <= 1) begin
                     state_d   = SCAN;
                     col_idx_d = col_idx_q + 2'd1;
                     cnt_d     = '0;
                  end else begin
                     cnt_d   = CW'(1);
                     state_d = RELEASE;
                  end
               end else if (rep_hit) begin
                  emit = 1'b1;
               end
            end
            default: begin
               if (press) begin
                  state_d = HELD;
                  cnt_d   = '0;
               end else if (cnt_q == CW'(DEBOUNCE_CNT - 1)) begin
                  state_d   = SCAN;
                  col_idx_d = col_idx_q + 2'd1;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= SCAN;
         dwell_q     <= '0;
         col_idx_q   <= '0;
         cand_q      <= '0;
         cnt_q       <= '0;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         dwell_q   <= dwell_d;
         col_idx_q <= col_idx_d;
         cand_q    <= cand_d;
         cnt_q     <= cnt_d;
         if (emit) begin
            key_code_q  <= cand_d;
            key_valid_q <= 1'b1;
            // An ack in the emitting cycle consumes the old key, so no overrun.
            overrun_q   <= key_valid_q && !kp.key_ack;
         end else begin
            overrun_q <= 1'b0;
            if (kp.key_ack && key_valid_q) key_valid_q <= 1'b0;
         end
      end
   end

   assign col_o        = ~(4'b0001 << col_idx_q);
   assign kp.key_code  = key_code_q;
   assign kp.key_valid = key_valid_q;
   assign kp.overrun   = overrun_q;
   assign kp.key_held  = (state_q == HELD) || (state_q == RELEASE);
endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 100000: clk cycles each column is driven (dwell; 1 ms at 100 MHz).
REQ-002 SHALL provide parameter DEBOUNCE_CNT, default 10: consecutive matching samples needed to accept a press or a release.
REQ-003 SHALL provide parameter REPEAT_CNT, default 250: samples between auto-repeat emissions (used only with KEYPAD_REPEAT_EN).
REQ-004 clk  input  1  system clock; all state is clocked on its rising edge.
REQ-005 rst  input  1  one clock; reset is asynchronous and active-low.
REQ-006 row  input  4  keypad row sense lines, active-low, externally pulled up.
REQ-007 col  output  4  keypad column drive, one-hot active-low.
REQ-008 key_code  output  4  accepted key, encoded as row_index*4 + col_index.
REQ-009 key_valid  output  1  key_code holds an unconsumed key.
REQ-010 key_ack  input  1  consumer accepts key_code; sampled only while key_valid=1.
REQ-011 key_held  output  1  high while an accepted key remains pressed.
REQ-012 overrun  output  1  one-cycle pulse when an unacknowledged key is overwritten.

Function
REQ-013 A dwell counter SHALL count 0..SCAN_DIV-1 and wrap; the sample strobe SHALL fire on count SCAN_DIV-1, giving rows a full dwell to settle.
REQ-014 col SHALL equal ~(4'b0001 << col_idx); col_idx advances 0->1->2->3->0 on each strobe, but only in state SCAN.
REQ-015 At a strobe, press is detected if any row bit is 0; with several rows low, the lowest row index SHALL win.
REQ-016 State machine SHALL have states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-017 SCAN: strobe with press -> record candidate {row,col_idx}, sample count=1, go DEBOUNCE, col_idx frozen; strobe without press -> advance col_idx.
REQ-018 DEBOUNCE: strobe with same candidate increments count; on reaching DEBOUNCE_CNT SHALL emit the key (REQ-022) and go HELD; strobe with different or no press -> SCAN, col_idx advances.
REQ-019 HELD: key_held=1; strobe with no press -> release count=1, go RELEASE; press of any row in the frozen column keeps HELD.
REQ-020 RELEASE: key_held stays 1; strobe with no press increments release count; at DEBOUNCE_CNT -> SCAN with key_held=0 and col_idx advanced; any press -> back to HELD, count cleared.
REQ-021 DEBOUNCE_CNT=1 SHALL accept on the first detecting strobe (SCAN direct to HELD, emitting same cycle).
REQ-022 Emit: key_code<=candidate, key_valid<=1 on the cycle after the accepting strobe (latency 1 clk).
REQ-023 key_valid SHALL clear the cycle after key_ack=1 with key_valid=1; key_ack while key_valid=0 is ignored.
REQ-024 Emit while key_valid=1 and no ack in that cycle: key_code overwritten, key_valid stays 1, overrun pulses one cycle.
REQ-025 Emit in the same cycle as key_ack: new key loaded, key_valid stays 1, no overrun.
REQ-026 Internal counters SHALL be sized $clog2 of their maximum+1 and SHALL never wrap except the dwell counter.

Reset
REQ-027 rst=0 SHALL immediately force: state SCAN, col_idx=0 (col=4'b1110), dwell and sample counters 0, key_code=0, key_valid=0, key_held=0, overrun=0.
REQ-028 Reset asserted mid-debounce or mid-hold SHALL discard the candidate with no emission; after release of rst scanning restarts from column 0.

Configuration
REQ-029 Macro KEYPAD_REPEAT_EN defined: in HELD, after REPEAT_CNT strobes since acceptance and every REPEAT_CNT strobes thereafter, SHALL re-emit the held key per REQ-022/024/025; the repeat counter clears on entering HELD from DEBOUNCE and freezes in RELEASE.
REQ-030 Macro undefined: exactly one emission per press; REPEAT_CNT unused and no repeat logic synthesized.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_CNT=5)
REQ-031 No press: col cycles 1110,1101,1011,0111,1110 changing every 4 clk; key_valid stays 0.
REQ-032 Row 2 low whenever col=1101, held 20 strobes -> col freezes at 1101, key_code=9, key_valid=1 one clk after 3rd matching strobe; key_held=1; ack -> key_valid=0 next clk.
REQ-033 Row 0 low for only 2 strobes in column 3 -> no emission, scanning resumes at column 0.
REQ-034 Key 9 accepted and unacked, released (3 strobes), then key 4 pressed -> key_code=4, overrun pulse 1 clk; repeat with ack on emit cycle -> no overrun.
REQ-035 rst=0 during DEBOUNCE -> col=1110 and all outputs 0 immediately, no later emission of the candidate.
REQ-036 KEYPAD_REPEAT_EN defined, key held 16 strobes with ack each emission -> emissions at acceptance, +5, +10, +15 strobes; undefined -> single emission.
